pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_if.sv | 27 ++
 rtl/pipe_adder.sv | 158 +++++++++++++++
 tb/tb_pipe_adder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The block consumes the slave view; the upstream/downstream side uses master.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Carry-segmented pipelined adder/subtractor with a single global advance enable.
// Define PIPE_ADDER_SAT_EN to clamp the result to the signed limit on overflow.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    logic en_s;
    logic ovf_now_s;
    logic ovf_q;
    logic ovf_d;

    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RIN = WIDTH - k * SEG;
        localparam int SW  = (k + 1) * SEG;

        logic           v_q, v_d;
        logic           c_q, c_d;
        logic [SW-1:0]  s_q, s_d, s_raw;
        logic           src_v, src_c;
        logic [RIN-1:0] src_a, src_b;
        logic [SEG:0]   seg_s;

        // Stage 0 takes the raw beat; later stages take what the previous stage registered
        if (k == 0) begin : g_head
            assign src_v = bus.in_valid;
            assign src_a = bus.a;
            assign src_b = bus.sub ? ~bus.b : bus.b;
            assign src_c = bus.sub ? 1'b1 : bus.cin;
            assign s_raw = seg_s[SEG-1:0];
        end else begin : g_body
            assign src_v = g_stg[k-1].v_q;
            assign src_a = g_stg[k-1].g_rem.a_q;
            assign src_b = g_stg[k-1].g_rem.b_q;
            assign src_c = g_stg[k-1].c_q;
            assign s_raw = {seg_s[SEG-1:0], g_stg[k-1].s_q};
        end

        assign seg_s = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, src_c};

        // Valid and carry advance together under the global enable
        always_comb begin
            if (en_s) begin
                v_d = src_v;
                c_d = seg_s[SEG];
            end else begin
                v_d = v_q;
                c_d = c_q;
            end
        end

        if (k == STAGES - 1) begin : g_out
            // Final stage: optional clamp of the completed sum
            always_comb begin
                if (!en_s) begin
                    s_d = s_q;
                end else begin
`ifdef PIPE_ADDER_SAT_EN
                    if (ovf_now_s) begin
                        s_d = src_a[RIN-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
                    end else begin
                        s_d = s_raw;
                    end
`else
                    s_d = s_raw;
`endif
                end
            end
        end else begin : g_mid
            // Intermediate stage: accumulate the low sum segments
            always_comb begin
                if (en_s) begin
                    s_d = s_raw;
                end else begin
                    s_d = s_q;
                end
            end
        end

        if (k < STAGES - 1) begin : g_rem
            localparam int ROUT = RIN - SEG;
            logic [ROUT-1:0] a_q, a_d, b_q, b_d;

            // Upper operand segments still waiting for their turn in the carry chain
            always_comb begin
                if (en_s) begin
                    a_d = src_a[RIN-1:SEG];
                    b_d = src_b[RIN-1:SEG];
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end

            // Operand skew registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= {ROUT{1'b0}};
                    b_q <= {ROUT{1'b0}};
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // Stage valid, carry and partial-sum registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= {SW{1'b0}};
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end
    end

    assign en_s      = !g_stg[STAGES-1].v_q || bus.out_ready;
    assign ovf_now_s = ovf_calc(g_stg[STAGES-1].src_a[SEG-1],
                                g_stg[STAGES-1].src_b[SEG-1],
                                g_stg[STAGES-1].seg_s[SEG-1]);

    // Overflow flag is judged on the unclamped top segment
    always_comb begin
        if (en_s) begin
            ovf_d = ovf_now_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.sum       = g_stg[STAGES-1].s_q;
    assign bus.cout      = g_stg[STAGES-1].c_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4); honours PIPE_ADDER_SAT_EN.
module tb_pipe_adder;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_out  = 0;
    int last_acc = 0;
    bit rnd_ready = 1'b0;
    logic [W+1:0] exp_q[$];
    int out_cyc_q[$];
    logic stall_seen = 1'b0;
    logic [W+1:0] held;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        longint sa, sb, sr, maxv, minv;
        logic [W:0] u;
        logic [W-1:0] s;
        logic co, ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        maxv = (64'sd1 <<< (W - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (W - 1));
        if (sub) begin
            u  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            co = u[W];
            sr = sa + sb + longint'(cin);
        end
        s  = u[W-1:0];
        ov = (sr > maxv) || (sr < minv);
`ifdef PIPE_ADDER_SAT_EN
        if (ov) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {ov, co, s};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (stall_seen) begin
                check_eq("stall_valid", bus.out_valid, 1);
                check_eq("stall_hold", {bus.ovf, bus.cout, bus.sum}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("result", {bus.ovf, bus.cout, bus.sum}, exp_q.pop_front());
                n_out++;
                out_cyc_q.push_back(cyc);
            end
            stall_seen = bus.out_valid && !bus.out_ready;
            held = {bus.ovf, bus.cout, bus.sum};
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                last_acc = cyc;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check_eq("accept_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_out >= target) break;
            @(negedge clk);
        end
        check_eq("out_timeout", n_out >= target, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, qbase, first_acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        #12;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_sum", bus.sum, 0);
        check_eq("rst_cout", bus.cout, 0);
        check_eq("rst_ovf", bus.ovf, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full carry ripple through every segment, plus latency
        base = n_out;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(base + 1, 20);
        check_eq("latency_carry", out_cyc_q[$] - last_acc, S);

        // Subtract, ignored cin, signed overflow corners
        base = n_out;
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0);
        wait_out(base + 7, 40);

        // Back-to-back with no stalls
        base = n_out;
        qbase = out_cyc_q.size();
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 0) first_acc = last_acc;
        end
        wait_out(base + 8, 40);
        for (int i = 0; i < 8; i++) check_eq("b2b_cycle", out_cyc_q[qbase + i], first_acc + S + i);

        // Random backpressure
        rnd_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_out(base + 10, 200);
        rnd_ready = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset with beats in flight
        base = n_out;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        send(32'd3, 32'd4, 1'b0, 1'b0);
        send(32'd5, 32'd6, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_eq("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("async_rst_valid", bus.out_valid, 0);
        check_eq("async_rst_sum", bus.sum, 0);
        check_eq("async_rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("no_out_after_rst", n_out, base);
        @(posedge clk); #1;
        send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
        wait_out(base + 1, 20);
        check_eq("latency_after_rst", out_cyc_q[$] - last_acc, S);

        check_eq("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
